// File: rtl/instr_cache_pkg.sv
// rtl/instr_cache_pkg.sv - shared types and geometry constants for the instruction cache
package instr_cache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 4;
    localparam int BLOCK_W  = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/icache_store.sv
// rtl/icache_store.sv - valid/tag/data line storage: one combinational read port, one clocked write port
module icache_store
    import instr_cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLOCK_W-1:0] o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_data
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

    // Only valid bits are reset; tag and data are meaningless until a line is marked valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with zero-cycle hits and block refill FSM
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [9:0]                 address,
    input  logic                       read,
    output logic [31:0]                readdata,
    output logic                       busywait,
    output logic                       mem_read,
    output logic [TAG_W+INDEX_W-1:0]   mem_address,
    input  logic [BLOCK_W-1:0]         mem_readdata,
    input  logic                       mem_busywait
);

    localparam int WSEL_W = $clog2(BLOCK_WORDS);

    state_t               r_state;
    state_t               w_next;
    logic [TAG_W-1:0]     r_tag;
    logic [INDEX_W-1:0]   r_index;
    logic [BLOCK_W-1:0]   r_block;
    logic [31:0]          r_readdata;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_index;
    logic [WSEL_W-1:0]    w_wsel;
    logic                 w_line_valid;
    logic [TAG_W-1:0]     w_line_tag;
    logic [BLOCK_W-1:0]   w_line_data;
    logic [31:0]          w_word;
    logic                 w_hit;
    logic                 w_mem_read;
    logic                 w_wr_en;
    logic                 w_unused_bits;

    assign w_tag         = address[9:7];
    assign w_index       = address[6:4];
    assign w_wsel        = address[OFFSET_W-1 -: WSEL_W];
    assign w_unused_bits = ^address[1:0];

    icache_store #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_store (
        .i_clk      (CLK),
        .i_rst_n    (RESET),
        .i_rd_index (w_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_index),
        .i_wr_tag   (r_tag),
        .i_wr_data  (r_block)
    );

    assign w_word = w_line_data[32*w_wsel +: 32];
    assign w_hit  = read & w_line_valid & (w_line_tag == w_tag);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Refill uses the tag/index latched at the miss edge, so CPU address wobble cannot redirect it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tag      <= '0;
            r_index    <= '0;
            r_block    <= '0;
            r_readdata <= 32'h0;
        end else begin
            if (r_state == IDLE && w_next == MEM_READ) begin
                r_tag   <= w_tag;
                r_index <= w_index;
            end
            if (r_state == MEM_READ && !mem_busywait) begin
                r_block <= mem_readdata;
            end
            if (w_hit) begin
                r_readdata <= w_word;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mem_read = 1'b0;
        w_wr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (read && !w_hit) begin
                    w_next = MEM_READ;
                end
            end
            MEM_READ: begin
                w_mem_read = 1'b1;
                if (!mem_busywait) begin
                    w_next = UPDATE;
                end
            end
            UPDATE: begin
                w_wr_en = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busywait    = read & ~w_hit;
    assign readdata    = w_hit ? w_word : r_readdata;
    assign mem_read    = w_mem_read;
    assign mem_address = {r_tag, r_index};

endmodule
